// File: rtl/unpacker_pkg.sv
// rtl/unpacker_pkg.sv - shared types and default sizing for the bit-stream unpacker
package unpacker_pkg;

    localparam int DEF_BUF_BITS = 32;
    localparam int DEF_WIN_BITS = 16;
    localparam int DEF_CNT_W    = $clog2(DEF_BUF_BITS + 1);
    localparam int DEF_CB_W     = $clog2(DEF_WIN_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/unpacker_bitbuf.sv
// rtl/unpacker_bitbuf.sv - bit buffer with shift-merge datapath and masked look-ahead window
module unpacker_bitbuf
    import unpacker_pkg::*;
#(
    parameter int BUF_BITS = DEF_BUF_BITS,
    parameter int WIN_BITS = DEF_WIN_BITS,
    parameter int CNT_W    = $clog2(BUF_BITS + 1),
    parameter int K_W      = $clog2(WIN_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                accept,
    input  logic [7:0]          packet_data,
    input  logic [K_W-1:0]      k,
    input  logic                flush_clr,
    output logic [WIN_BITS-1:0] window,
    output logic [CNT_W-1:0]    cnt,
    output logic [CNT_W-1:0]    cnt_next
);

    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    k_ext;
    logic [CNT_W-1:0]    base;
    logic [WIN_BITS-1:0] mask;

    always_comb begin
        k_ext = CNT_W'(k);
        base  = cnt_q - k_ext;
        buf_d = buf_q >> k_ext;
        cnt_d = base;
        // The new byte lands directly above whatever survives this cycle's consume.
        if (accept) begin
            buf_d = buf_d | (BUF_BITS'(packet_data) << base);
            cnt_d = base + CNT_W'(8);
        end
        if (flush_clr) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIN_BITS; i++) begin
            mask[i] = (CNT_W'(i) < cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign window   = buf_q[WIN_BITS-1:0] & mask;
    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;

endmodule

// File: rtl/unpacker.sv
// rtl/unpacker.sv - receive-side unpacker: packet intake, stream FSM, consume legality
module unpacker
    import unpacker_pkg::*;
#(
    parameter int BUF_BITS = DEF_BUF_BITS,
    parameter int WIN_BITS = DEF_WIN_BITS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               packet_valid,
    input  logic [7:0]                         packet_data,
    input  logic                               last_packet,
    output logic                               packet_ready,
    output logic [WIN_BITS-1:0]                window,
    output logic [$clog2(BUF_BITS+1)-1:0]      bit_count,
    input  logic                               consume,
    input  logic [$clog2(WIN_BITS+1)-1:0]      consume_bits,
    input  logic                               flush,
    output logic                               stream_done,
    output logic                               proto_err
);

    localparam int CNT_W = $clog2(BUF_BITS + 1);
    localparam int K_W   = $clog2(WIN_BITS + 1);

    state_e           state_q, state_d;
    logic             proto_err_q, proto_err_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [K_W-1:0]   k;
    logic             legal;
    logic             flush_eff;
    logic             accept;

    always_comb begin
        legal        = (CNT_W'(consume_bits) <= cnt) && (consume_bits <= K_W'(WIN_BITS));
        flush_eff    = flush && ((state_q == ST_FILL) || (state_q == ST_DRAIN));
        // Readiness looks only at the current fill level, never at this cycle's consume.
        packet_ready = ((state_q == ST_IDLE) || (state_q == ST_FILL)) &&
                       (cnt <= CNT_W'(BUF_BITS - 8));
        accept       = packet_valid && packet_ready && !flush_eff;
        k            = (consume && legal && !flush_eff) ? consume_bits : '0;
        proto_err_d  = proto_err_q | (consume && !legal);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = last_packet ? ST_DRAIN : ST_FILL;
            end
            ST_FILL: begin
                if (flush)                      state_d = ST_DONE;
                else if (accept && last_packet) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush || (cnt_next == '0)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
        end
    end

    unpacker_bitbuf #(
        .BUF_BITS(BUF_BITS),
        .WIN_BITS(WIN_BITS),
        .CNT_W   (CNT_W),
        .K_W     (K_W)
    ) u_bitbuf (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept),
        .packet_data(packet_data),
        .k          (k),
        .flush_clr  (flush_eff),
        .window     (window),
        .cnt        (cnt),
        .cnt_next   (cnt_next)
    );

    assign bit_count   = cnt;
    assign stream_done = (state_q == ST_DONE);
    assign proto_err   = proto_err_q;

endmodule

// File: doc/unpacker.md
# unpacker

- Receive side of the compressed-byte link: the inverse of the Huffman code packer.
- Accepts 8-bit packets over a valid/ready handshake and keeps them in a bit buffer.
- Presents a WIN_BITS-wide look-ahead window of the bit stream to the Huffman decoder, which consumes a variable number of bits per cycle.
- Marks end of stream once the last packet has drained or the decoder flushes.

## Interface
Parameters:
- BUF_BITS, 32: bit-buffer capacity; multiple of 8, ≥ WIN_BITS+8.
- WIN_BITS, 16: look-ahead window width; maximum bits consumable per cycle.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- packet_valid  in  1  packet_data/last_packet valid this cycle.
- packet_data  in  8  compressed byte; bit 0 is the earliest stream bit.
- last_packet  in  1  qualifies packet_data as the final byte of the stream.
- packet_ready  out  1  byte accepted at the edge when packet_valid && packet_ready.
- window  out  WIN_BITS  next stream bits; window[0] is the next bit; positions ≥ bit_count read 0.
- bit_count  out  $clog2(BUF_BITS+1)  valid bits held in the buffer.
- consume  in  1  decoder removes consume_bits bits this cycle.
- consume_bits  in  $clog2(WIN_BITS+1)  0..WIN_BITS.
- flush  in  1  decoder found end-of-block; discard the buffer and end the stream.
- stream_done  out  1  one-cycle pulse at end of stream.
- proto_err  out  1  sticky; set on an illegal consume; cleared only by rst.

## Operation
- State: buffer buf[BUF_BITS-1:0] and count cnt. Valid bits are buf[cnt-1:0], earliest at bit 0.
- A legal consume requires consume_bits ≤ cnt and consume_bits ≤ WIN_BITS.
- An illegal consume sets proto_err and is ignored. A byte accept in the same cycle still proceeds.
- Byte accept: the byte lands at bit position cnt-k, where k is the legal consume amount (else 0).
- Next-state datapath, in one cycle:
  - buf' = (buf >> k) | (packet_data << (cnt-k))
  - cnt' = cnt - k + 8·accept
- packet_ready = (state ∈ {IDLE, FILL}) && cnt ≤ BUF_BITS-8. It depends on current cnt only, never on same-cycle consume.
- FSM states:
  - IDLE: cnt = 0, ready allowed. Accept with last_packet=0 → FILL. Accept with last_packet=1 → DRAIN.
  - FILL: accept with last_packet=1 → DRAIN. Otherwise stay.
  - DRAIN: packet_ready = 0. Go to DONE when cnt' = 0 or flush.
  - DONE: stream_done = 1, packet_ready = 0, cnt = 0. Next cycle → IDLE.
- flush handling:
  - In FILL or DRAIN: cnt' = 0, buf' = 0, → DONE. Any same-cycle accept or consume is discarded.
  - In IDLE or DONE: no effect.
- Padding bits in the final byte stay in the buffer until consumed or flushed. Ending on padding is the decoder's job, via flush.

## Timing
- Reset values:
  - Registers: state = IDLE, cnt = 0, buf = 0.
  - Outputs: window = 0, bit_count = 0, packet_ready = 1, stream_done = 0, proto_err = 0.
- Latency: a byte accepted at edge N is visible in window/bit_count after edge N.
- window and bit_count are combinational from registers, so the decoder may consume in the same cycle it sees them.
- Consume takes effect at the same edge. Back-to-back consumes every cycle are supported.
- A simultaneous accept and consume in a cycle with cnt = BUF_BITS-8 is legal and gives cnt' = BUF_BITS-k.
- Full: cnt > BUF_BITS-8 → packet_ready = 0. The producer must hold packet_valid and packet_data stable.
- Empty: cnt = 0 → window = 0. Any consume_bits > 0 is an error.
- rst mid-stream returns all reset values at the next edge, regardless of state.

## Structure
- Package unpacker_pkg holds:
  - state enum {IDLE, FILL, DRAIN, DONE}
  - localparams for the cnt and consume_bits widths
  - default BUF_BITS and WIN_BITS
- Sub-module unpacker_bitbuf: the buf/cnt registers, shift-merge datapath, and window masking. Inputs: accept, k, flush_clr.
- Top-level unpacker: FSM, packet_ready, legality check, proto_err, stream_done.

## Test plan
1. Fill and peek: after reset, send 8'hA5 then 8'h3C (not last) → bit_count = 16, window = 16'h3CA5.
2. Concurrent accept and consume: cnt = 16, window = 16'h3CA5. Consume 5 while sending 8'hFF → window = 16'hF9E5, bit_count = 19.
3. Backpressure: send four bytes with no consume → packet_ready = 0 when cnt = 32. A fifth valid byte is held until a consume of ≥ 8, then accepted.
4. Drain: send one byte 8'h0F with last_packet = 1, then consume 4 and 4.
   - packet_ready = 0 throughout DRAIN.
   - stream_done pulses the cycle after the second consume.
   - IDLE follows, with packet_ready = 1.
5. Illegal consume: cnt = 3, consume_bits = 5 → proto_err = 1, cnt stays 3. A later reset clears proto_err.
6. Flush: cnt = 12 in FILL, assert flush with packet_valid high → byte not accepted, next cycle bit_count = 0 and stream_done = 1, then IDLE.
